// File: rtl/gnss_sample_capture.sv
// Captures a burst of decimated, quantised I/Q samples and packs them into memory words.
// Words are written one cycle after the sample that completes them; no back-pressure.
module gnss_sample_capture #(
    parameter int SRC_WIDTH   = 8,
    parameter int CH_BITS     = 1,
    parameter int SEL_MSB     = 2,
    parameter int WORD_WIDTH  = 36,
    parameter int ADDR_WIDTH  = 14,
    parameter int DECIM_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH:0]    num_words,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic                   sample_valid,
    input  logic [SRC_WIDTH-1:0]   adc_i,
    input  logic [SRC_WIDTH-1:0]   adc_q,
    output logic [WORD_WIDTH-1:0]  mem_di,
    output logic [ADDR_WIDTH-1:0]  mem_ad,
    output logic                   mem_wre,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH:0]    words_written
);

    localparam int SLOT_W  = 2 * CH_BITS;
    localparam int SPW     = WORD_WIDTH / SLOT_W;
    localparam int SLOT_IW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [SLOT_IW-1:0] LAST_SLOT = SLOT_IW'(SPW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    num_words_q, num_words_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [SLOT_IW-1:0]     slot_q, slot_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WORD_WIDTH-1:0]  mem_di_q, mem_di_d;
    logic [ADDR_WIDTH-1:0]  mem_ad_q, mem_ad_d;
    logic                   mem_wre_q, mem_wre_d;
    logic                   done_q, done_d;
    logic [ADDR_WIDTH:0]    words_written_q, words_written_d;

    logic [SLOT_W-1:0]      kept_slot;
    logic [WORD_WIDTH-1:0]  word_fill;
    logic                   unused_adc_bits;

    assign unused_adc_bits = ^{adc_i, adc_q};

    always_comb begin
        state_d         = state_q;
        num_words_d     = num_words_q;
        decim_d         = decim_q;
        dcnt_d          = dcnt_q;
        slot_d          = slot_q;
        word_d          = word_q;
        addr_d          = addr_q;
        mem_di_d        = mem_di_q;
        mem_ad_d        = mem_ad_q;
        mem_wre_d       = 1'b0;
        done_d          = done_q;
        words_written_d = words_written_q;

        kept_slot = {adc_q[SEL_MSB -: CH_BITS], adc_i[SEL_MSB -: CH_BITS]};
        word_fill = word_q;
        word_fill[int'(slot_q) * SLOT_W +: SLOT_W] = kept_slot;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_CAPTURE;
                    num_words_d     = num_words;
                    decim_d         = decim;
                    dcnt_d          = '0;
                    slot_d          = '0;
                    word_d          = '0;
                    addr_d          = '0;
                    mem_ad_d        = '0;
                    done_d          = 1'b0;
                    words_written_d = '0;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    slot_d  = '0;
                    word_d  = '0;
                end else if (num_words_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (sample_valid) begin
                    dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
                    // Only the first sample of each decimation group is kept.
                    if (dcnt_q == '0) begin
                        if (slot_q == LAST_SLOT) begin
                            mem_wre_d       = 1'b1;
                            mem_di_d        = word_fill;
                            mem_ad_d        = addr_q;
                            addr_d          = addr_q + 1'b1;
                            slot_d          = '0;
                            word_d          = '0;
                            words_written_d = words_written_q + 1'b1;
                            if (words_written_d == num_words_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            word_d = word_fill;
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            num_words_q     <= '0;
            decim_q         <= '0;
            dcnt_q          <= '0;
            slot_q          <= '0;
            word_q          <= '0;
            addr_q          <= '0;
            mem_di_q        <= '0;
            mem_ad_q        <= '0;
            mem_wre_q       <= 1'b0;
            done_q          <= 1'b0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            num_words_q     <= num_words_d;
            decim_q         <= decim_d;
            dcnt_q          <= dcnt_d;
            slot_q          <= slot_d;
            word_q          <= word_d;
            addr_q          <= addr_d;
            mem_di_q        <= mem_di_d;
            mem_ad_q        <= mem_ad_d;
            mem_wre_q       <= mem_wre_d;
            done_q          <= done_d;
            words_written_q <= words_written_d;
        end
    end

    assign mem_di        = mem_di_q;
    assign mem_ad        = mem_ad_q;
    assign mem_wre       = mem_wre_q;
    assign busy          = (state_q == S_CAPTURE);
    assign done          = done_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_gnss_sample_capture.sv
// Directed bench for gnss_sample_capture: 1-bit instance for most scenarios, 2-bit instance for packing.
module tb_gnss_sample_capture;

    localparam int AW = 14;
    localparam int WW = 36;

    logic          clk = 1'b0;
    logic          rst, start, abort, sample_valid;
    logic [AW:0]   num_words;
    logic [3:0]    decim;
    logic [7:0]    adc_i, adc_q;

    logic [WW-1:0] mem_di, mem_di2;
    logic [AW-1:0] mem_ad, mem_ad2;
    logic          mem_wre, mem_wre2, busy, busy2, done, done2;
    logic [AW:0]   words_written, words_written2;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] wr_di[$];
    logic [AW-1:0] wr_ad[$];
    logic          wr_done[$];
    logic          wr_busy[$];
    logic [AW:0]   wr_ww[$];
    logic [WW-1:0] wr2_di[$];
    logic [AW-1:0] wr2_ad[$];

    always #5 clk = ~clk;

    gnss_sample_capture dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_words(num_words), .decim(decim), .sample_valid(sample_valid),
        .adc_i(adc_i), .adc_q(adc_q), .mem_di(mem_di), .mem_ad(mem_ad),
        .mem_wre(mem_wre), .busy(busy), .done(done), .words_written(words_written)
    );

    gnss_sample_capture #(.CH_BITS(2), .SEL_MSB(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_words(num_words), .decim(decim), .sample_valid(sample_valid),
        .adc_i(adc_i), .adc_q(adc_q), .mem_di(mem_di2), .mem_ad(mem_ad2),
        .mem_wre(mem_wre2), .busy(busy2), .done(done2), .words_written(words_written2)
    );

    always @(negedge clk) begin
        if (mem_wre === 1'b1) begin
            wr_di.push_back(mem_di);
            wr_ad.push_back(mem_ad);
            wr_done.push_back(done);
            wr_busy.push_back(busy);
            wr_ww.push_back(words_written);
        end
        if (mem_wre2 === 1'b1) begin
            wr2_di.push_back(mem_di2);
            wr2_ad.push_back(mem_ad2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_di.delete(); wr_ad.delete(); wr_done.delete(); wr_busy.delete(); wr_ww.delete();
        wr2_di.delete(); wr2_ad.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        adc_i = '0; adc_q = '0; num_words = '0; decim = '0;
        step(); step();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic start_cap(input logic [AW:0] nw, input logic [3:0] dc);
        start = 1'b1; num_words = nw; decim = dc;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] i, input logic [7:0] q);
        sample_valid = 1'b1; adc_i = i; adc_q = q;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, done, mem_wre, mem_ad, words_written, mem_di} !== '0) begin
            bad++; $display("FAIL reset_init: busy=%b done=%b wre=%b ad=%h ww=%0d di=%h want all 0",
                            busy, done, mem_wre, mem_ad, words_written, mem_di);
        end
        start_cap(1, 0);
        for (int k = 0; k < 5; k++) send(8'h04, 8'h04);
        rst = 1'b1; step(); step(); rst = 1'b0;
        total++;
        if ({busy, done, mem_wre, mem_ad} !== '0) begin
            bad++; $display("FAIL reset_mid: busy=%b done=%b wre=%b ad=%h want 0", busy, done, mem_wre, mem_ad);
        end
        clear_log();
        for (int k = 0; k < 20; k++) send(8'h04, 8'h04);
        step();
        total++;
        if (wr_ad.size() != 0) begin
            bad++; $display("FAIL reset_nowrite: writes=%0d want 0", wr_ad.size());
        end
    endtask

    task automatic test_sign_packing();
        logic [7:0] ai;
        do_reset();
        sample_valid = 1'b1; adc_i = 8'h04; adc_q = 8'h00;
        start_cap(2, 0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL sign_busy: busy=%b want 1", busy);
        end
        for (int k = 0; k < 36; k++) begin
            ai = 8'hA3 | ((k % 2 == 1) ? 8'h04 : 8'h00);
            send(ai, 8'h04);
        end
        step();
        total++;
        if (wr_ad.size() != 2) begin
            bad++; $display("FAIL sign_count: writes=%0d want 2", wr_ad.size());
        end else begin
            total++;
            if (wr_di[0] !== 36'hEEEEEEEEE || wr_ad[0] !== 14'd0) begin
                bad++; $display("FAIL sign_word0: di=%h ad=%0d want EEEEEEEEE ad 0", wr_di[0], wr_ad[0]);
            end
            total++;
            if (wr_di[1] !== 36'hEEEEEEEEE || wr_ad[1] !== 14'd1) begin
                bad++; $display("FAIL sign_word1: di=%h ad=%0d want EEEEEEEEE ad 1", wr_di[1], wr_ad[1]);
            end
            total++;
            if (wr_done[0] !== 1'b0 || wr_busy[0] !== 1'b1 || wr_ww[0] !== 15'd1) begin
                bad++; $display("FAIL sign_first_status: done=%b busy=%b ww=%0d want 0 1 1",
                                wr_done[0], wr_busy[0], wr_ww[0]);
            end
            total++;
            if (wr_done[1] !== 1'b1 || wr_busy[1] !== 1'b0 || wr_ww[1] !== 15'd2) begin
                bad++; $display("FAIL sign_final_status: done=%b busy=%b ww=%0d want 1 0 2",
                                wr_done[1], wr_busy[1], wr_ww[1]);
            end
        end
        total++;
        if (done !== 1'b1 || mem_wre !== 1'b0) begin
            bad++; $display("FAIL sign_done_sticky: done=%b wre=%b want 1 0", done, mem_wre);
        end
    endtask

    task automatic test_decimation();
        int nwr, wr_n, j;
        logic [7:0] ai, aq;
        do_reset();
        start_cap(1, 2);
        nwr = 0; wr_n = -1;
        for (int n = 0; n < 54; n++) begin
            j = n / 3;
            if (n % 3 == 0) begin
                ai = (j % 2 == 1) ? 8'h04 : 8'h00;
                aq = ((j / 2) % 2 == 1) ? 8'h04 : 8'h00;
            end else begin
                ai = 8'h04; aq = 8'h04;
            end
            send(ai, aq);
            if (mem_wre === 1'b1) begin
                nwr++; wr_n = n;
            end
        end
        step(); step();
        total++;
        if (nwr != 1 || wr_n != 51) begin
            bad++; $display("FAIL decim_timing: writes=%0d after_sample=%0d want 1 after 51", nwr, wr_n);
        end
        total++;
        if (wr_di.size() != 1) begin
            bad++; $display("FAIL decim_count: writes=%0d want 1", wr_di.size());
        end else begin
            total++;
            if (wr_di[0] !== 36'h4E4E4E4E4) begin
                bad++; $display("FAIL decim_word: di=%h want 4E4E4E4E4", wr_di[0]);
            end
        end
    endtask

    task automatic test_two_bit();
        do_reset();
        start_cap(1, 0);
        for (int k = 0; k < 9; k++) send(8'hF6, 8'hA3);
        step();
        total++;
        if (wr2_di.size() != 1) begin
            bad++; $display("FAIL twobit_count: writes=%0d want 1", wr2_di.size());
        end else begin
            total++;
            if (wr2_di[0] !== 36'h777777777 || wr2_ad[0] !== 14'd0) begin
                bad++; $display("FAIL twobit_word: di=%h ad=%0d want 777777777 ad 0", wr2_di[0], wr2_ad[0]);
            end
        end
        total++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++; $display("FAIL twobit_done: done=%b busy=%b want 1 0", done2, busy2);
        end
    endtask

    task automatic test_abort_restart();
        do_reset();
        start_cap(1, 0);
        for (int k = 0; k < 10; k++) send(8'h04, 8'h04);
        abort = 1'b1; step(); abort = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || words_written !== 15'd0 || wr_ad.size() != 0) begin
            bad++; $display("FAIL abort_partial: busy=%b done=%b ww=%0d writes=%0d want 0 0 0 0",
                            busy, done, words_written, wr_ad.size());
        end
        start_cap(3, 0);
        for (int k = 0; k < 23; k++) send(8'h04, 8'h04);
        abort = 1'b1; step(); abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || words_written !== 15'd1) begin
            bad++; $display("FAIL abort_hold_count: busy=%b done=%b ww=%0d want 0 0 1", busy, done, words_written);
        end
        clear_log();
        start_cap(1, 0);
        for (int k = 0; k < 18; k++) begin
            if (k % 2 == 1) send(8'h04, 8'h00);
            else            send(8'h00, 8'h04);
        end
        step();
        total++;
        if (wr_di.size() != 1) begin
            bad++; $display("FAIL restart_count: writes=%0d want 1", wr_di.size());
        end else begin
            total++;
            if (wr_di[0] !== 36'h666666666 || wr_ad[0] !== 14'd0) begin
                bad++; $display("FAIL restart_word: di=%h ad=%0d want 666666666 ad 0", wr_di[0], wr_ad[0]);
            end
        end
        total++;
        if (done !== 1'b1 || words_written !== 15'd1) begin
            bad++; $display("FAIL restart_done: done=%b ww=%0d want 1 1", done, words_written);
        end
    endtask

    task automatic test_edge_cases();
        do_reset();
        start_cap(0, 0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL zero_first: busy=%b done=%b want 1 0", busy, done);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL zero_done: busy=%b done=%b want 0 1", busy, done);
        end
        step(); step();
        total++;
        if (wr_ad.size() != 0) begin
            bad++; $display("FAIL zero_nowrite: writes=%0d want 0", wr_ad.size());
        end

        clear_log();
        start_cap(2, 0);
        for (int k = 0; k < 20; k++) send(8'h00, 8'h00);
        start = 1'b1; num_words = 15'd5;
        send(8'h00, 8'h00);
        start = 1'b0;
        for (int k = 0; k < 15; k++) send(8'h00, 8'h00);
        step();
        total++;
        if (wr_ad.size() != 2) begin
            bad++; $display("FAIL ignore_start_count: writes=%0d want 2", wr_ad.size());
        end else begin
            total++;
            if (wr_ad[0] !== 14'd0 || wr_ad[1] !== 14'd1) begin
                bad++; $display("FAIL ignore_start_addr: ad0=%0d ad1=%0d want 0 1", wr_ad[0], wr_ad[1]);
            end
        end
        total++;
        if (done !== 1'b1 || words_written !== 15'd2) begin
            bad++; $display("FAIL ignore_start_done: done=%b ww=%0d want 1 2", done, words_written);
        end

        start_cap(1, 0);
        for (int k = 0; k < 3; k++) send(8'h00, 8'h00);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        clear_log();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL start_abort: busy=%b done=%b want 0 0", busy, done);
        end
        for (int k = 0; k < 18; k++) send(8'h00, 8'h00);
        step();
        total++;
        if (wr_ad.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL start_abort_idle: writes=%0d busy=%b want 0 0", wr_ad.size(), busy);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        adc_i = '0; adc_q = '0; num_words = '0; decim = '0;
        test_reset();
        test_sign_packing();
        test_decimation();
        test_two_bit();
        test_abort_restart();
        test_edge_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gnss_sample_capture.md
# gnss_sample_capture

Captures a programmable-length burst of quantised I/Q ADC samples, packs them into memory-width words and writes them through a single-port block-RAM write interface for the acquisition engine to read back. It sits between the ADC front-end (samples qualified by a strobe in the system clock domain) and the 36-bit BSRAM sample buffer. It generalises the fixed 1-bit, 10-sample packing used to date to runtime length, decimation and selectable quantisation width.

## Interface

- SRC_WIDTH, 8: width of each raw I and Q input sample.
- CH_BITS, 1: bits kept per component (1 = sign only, 2 = sign+magnitude).
- SEL_MSB, 2: MSB of the kept field within the raw sample; kept field is [SEL_MSB -: CH_BITS].
- WORD_WIDTH, 36: memory data width.
- ADDR_WIDTH, 14: memory word-address width.
- DECIM_WIDTH, 4: width of the decimation control.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a capture.
- abort  in  1  stops a capture in progress.
- num_words  in  ADDR_WIDTH+1  words to capture; sampled on start.
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 samples; sampled on start.
- sample_valid  in  1  qualifies adc_i/adc_q this cycle.
- adc_i, adc_q  in  SRC_WIDTH each  raw samples.
- mem_di  out  WORD_WIDTH  packed word.
- mem_ad  out  ADDR_WIDTH  word address.
- mem_wre  out  1  write strobe, one cycle per word.
- busy  out  1  capture in progress.
- done  out  1  sticky completion flag.
- words_written  out  ADDR_WIDTH+1  words written in current/last capture.

## Operation

- SPW (samples per word) = WORD_WIDTH / (2*CH_BITS), integer division; default 18. Unused top bits of mem_di are 0.
- Slot k of a word occupies bits [k*2*CH_BITS +: 2*CH_BITS]: I field in the low CH_BITS, Q field in the high CH_BITS. Slot 0 is the earliest sample.
- States: IDLE, CAPTURE, DONE.
- IDLE/DONE + start: latch num_words and decim; clear slot index, decimation counter, address, words_written and done; go to CAPTURE, busy=1. If latched num_words = 0: go straight to DONE next cycle, no writes.
- CAPTURE: each sample_valid advances the decimation counter (0..decim, wraps); the sample is kept only when the counter is 0 before advancing. Kept sample is written into the current slot.
- When slot SPW-1 is filled, the word is emitted and the slot index returns to 0; mem_ad increments after each write.
- After the num_words-th write: state DONE, busy=0, done=1.
- start in CAPTURE is ignored.
- abort in CAPTURE: go to IDLE, busy=0, done stays 0, partial word discarded, words_written holds the count reached. abort outside CAPTURE has no effect. abort and start in the same cycle: abort wins.
- mem_ad wraps modulo 2^ADDR_WIDTH; num_words above 2^ADDR_WIDTH overwrites from address 0.
- rst: state IDLE; all outputs (mem_di, mem_ad, mem_wre, busy, done, words_written) = 0.

## Timing

- start at edge t: busy=1 from t+1. A sample_valid in cycle t (the start cycle) is not captured; first candidate is the cycle after start.
- Write latency: the sample_valid cycle filling the last slot is cycle s; mem_wre=1 with mem_di/mem_ad registered in cycle s+1 for exactly one cycle.
- Final word: busy falls, done rises and words_written = num_words in the same cycle as its mem_wre.
- Throughput: sample_valid may be high every cycle; no back-pressure, no sample loss.
- done stays 1 until the next accepted start or rst.

## Test plan

- Reset: assert rst 2 cycles mid-capture -> next cycle busy=0, done=0, mem_wre=0, mem_ad=0, no further writes.
- Sign packing: CH_BITS=1, num_words=2, decim=0, 36 consecutive samples with adc_i bit2 = k[0], adc_q bit2 = 1 -> word 0 at mem_ad=0 equals 0xEEEEEEEEE masked pattern (I=0,1,0,1...; Q all 1), i.e. slot k = {1, k[0]}; second write mem_ad=1; done with 2nd mem_wre.
- Decimation: decim=2, num_words=1, 54 samples numbered 0..53 -> word holds samples 0,3,6,...,51; exactly one mem_wre one cycle after sample 51.
- 2-bit mode: CH_BITS=2, SEL_MSB=2 -> SPW=9; 9 samples adc_i=3'b110, adc_q=3'b011 -> mem_di = 9 repeats of 4'b0111 (0xFFFFFFFFF & pattern 0x777777777); top 0 bits unused.
- Abort/restart: abort after 10 of 18 samples -> no write, busy=0, done=0; new start with num_words=1 -> write at mem_ad=0 after 18 fresh samples.
- Edge cases: num_words=0 -> done=1 two cycles after start, no mem_wre; start during CAPTURE ignored (address sequence unchanged); start+abort same cycle in CAPTURE -> IDLE.
